// File: rtl/debounce_pkg.sv
// Shared types and defaults for the key debouncer.
// Channel FSM encoding plus debounce-length limits.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int DEBOUNCE_MIN     = 2;
  localparam int N_MAX            = 32;

endpackage

// File: rtl/key_debounce_if.sv
// Signal bundle for the key debouncer.
// master drives raw keys and clears; slave returns debounced state.
interface key_debounce_if #(
  parameter int N = 4
);

  logic [N-1:0] din;
  logic [N-1:0] clr;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] event_flag;
  logic         irq;

  modport master (
    output din, clr,
    input  dout, rise, fall, event_flag, irq
  );

  modport slave (
    input  din, clr,
    output dout, rise, fall, event_flag, irq
  );

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, 4-state FSM,
// saturating-free stability counter and edge pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam deb_state_e RST_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Commit on the cycle the count would reach DEBOUNCE_CYCLES,
  // so dout moves DEBOUNCE_CYCLES+2 edges after din is sampled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dout = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    rise = rise_q;
    fall = fall_q;
  end

endmodule

// File: rtl/key_debounce.sv
// N-channel key debouncer with optional sticky event flags/irq.
// Sticky events are built only when KEY_DEBOUNCE_EVENT_EN is defined.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int           N               = 4,
  parameter int           DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [N-1:0] RESET_VAL       = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  input  logic [N-1:0] clr,
  output logic [N-1:0] event_flag,
  output logic         irq
);

  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_cycles
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("key_debounce: N must be in 1..32");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[gi])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (din[gi]),
      .dout    (dout[gi]),
      .rise    (rise[gi]),
      .fall    (fall[gi])
    );
  end

`ifdef KEY_DEBOUNCE_EVENT_EN
  logic [N-1:0] flag_q, flag_d;
  logic         irq_q, irq_d;

  // A new edge beats a clear arriving in the same cycle.
  always_comb begin
    flag_d = (flag_q & ~clr) | rise | fall;
    irq_d  = |flag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= irq_d;
    end
  end

  assign event_flag = flag_q;
  assign irq        = irq_q;
`else
  logic unused_clr;
  assign unused_clr = ^clr;
  assign event_flag = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (N=4, DEBOUNCE_CYCLES=8).
// Expected pulses are queued by stimulus and checked by a monitor.
module tb_key_debounce;

  localparam int N = 4;
  localparam int D = 8;
`ifdef KEY_DEBOUNCE_EVENT_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  typedef struct {
    int       cyc;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  exp_t mon_e;

  key_debounce_if #(.N(N)) bus ();

  key_debounce #(
    .N               (N),
    .DEBOUNCE_CYCLES (D),
    .RESET_VAL       (4'b1111)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (bus.din),
    .dout       (bus.dout),
    .rise       (bus.rise),
    .fall       (bus.fall),
    .clr        (bus.clr),
    .event_flag (bus.event_flag),
    .irq        (bus.irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(int c, logic [3:0] d, logic [3:0] r, logic [3:0] f);
    exp_t e;
    e.cyc  = c;
    e.dout = d;
    e.rise = r;
    e.fall = f;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if ((bus.rise | bus.fall) != 4'b0) begin
      chk("rise_fall_excl", 32'(bus.rise & bus.fall), 0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {24'b0, bus.rise, bus.fall}, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("pulse_dout", 32'(bus.dout), 32'(mon_e.dout));
        chk("pulse_rise", 32'(bus.rise), 32'(mon_e.rise));
        chk("pulse_fall", 32'(bus.fall), 32'(mon_e.fall));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic clear_flags();
    @(negedge clk);
    bus.clr = 4'b1111;
    @(negedge clk);
    bus.clr = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    int c;
    bus.din = 4'b1111;
    bus.clr = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 32'hf);
    chk("rst_rise", 32'(bus.rise), 0);
    chk("rst_fall", 32'(bus.fall), 0);
    chk("rst_flag", 32'(bus.event_flag), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_dout", 32'(bus.dout), 32'hf);
    chk("post_rst_flag", 32'(bus.event_flag), 0);
    chk("post_rst_irq", 32'(bus.irq), 0);

    // single channel fall
    @(negedge clk);
    bus.din[0] = 1'b0;
    c = cyc;
    push(c + 10, 4'b1110, 4'b0000, 4'b0001);
    wait_to(c + 9);
    chk("t2_dout_pre", 32'(bus.dout), 32'hf);
    wait_to(c + 11);
    chk("t2_flag", 32'(bus.event_flag), EV ? 32'h1 : 0);
    chk("t2_irq_early", 32'(bus.irq), 0);
    wait_to(c + 12);
    chk("t2_irq", 32'(bus.irq), 32'(EV));

    // rise with simultaneous clear, then clear alone
    bus.din[0] = 1'b1;
    c = cyc;
    push(c + 10, 4'b1111, 4'b0001, 4'b0000);
    wait_to(c + 10);
    bus.clr = 4'b0001;
    wait_to(c + 11);
    bus.clr = 4'b0000;
    chk("t3_set_wins", 32'(bus.event_flag), EV ? 32'h1 : 0);
    wait_to(c + 12);
    bus.clr = 4'b0001;
    wait_to(c + 13);
    bus.clr = 4'b0000;
    chk("t3_clr_flag", 32'(bus.event_flag), 0);
    wait_to(c + 14);
    chk("t3_clr_irq", 32'(bus.irq), 0);

    // short glitch on channel 1
    @(negedge clk);
    bus.din[1] = 1'b0;
    c = cyc;
    wait_to(c + 5);
    bus.din[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_glitch_dout", 32'(bus.dout), 32'hf);
    end
    chk("t4_flag", 32'(bus.event_flag), 0);

    // bouncing channel 2
    for (int b = 0; b < 3; b++) begin
      bus.din[2] = 1'b0;
      c = cyc;
      wait_to(c + 3);
      bus.din[2] = 1'b1;
      wait_to(c + 6);
    end
    bus.din[2] = 1'b0;
    c = cyc;
    push(c + 10, 4'b1011, 4'b0000, 4'b0100);
    wait_to(c + 12);
    chk("t5_flag", 32'(bus.event_flag), EV ? 32'h4 : 0);
    bus.din[2] = 1'b1;
    c = cyc;
    push(c + 10, 4'b1111, 4'b0100, 4'b0000);
    wait_to(c + 12);
    clear_flags();
    chk("t5_irq_cleared", 32'(bus.irq), 0);

    // two channels together
    bus.din = 4'b0101;
    c = cyc;
    push(c + 10, 4'b0101, 4'b0000, 4'b1010);
    wait_to(c + 12);
    chk("t6_flag", 32'(bus.event_flag), EV ? 32'ha : 0);
    bus.din = 4'b1111;
    c = cyc;
    push(c + 10, 4'b1111, 4'b1010, 4'b0000);
    wait_to(c + 12);
    clear_flags();

    // reset in the middle of a count
    bus.din[3] = 1'b0;
    c = cyc;
    wait_to(c + 7);
    reset_n = 1'b0;
    bus.din[3] = 1'b1;
    @(negedge clk);
    chk("t7_rst_dout", 32'(bus.dout), 32'hf);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    c = cyc;
    wait_to(c + 20);
    chk("t7_dout", 32'(bus.dout), 32'hf);
    chk("t7_flag", 32'(bus.event_flag), 0);
    chk("t7_irq", 32'(bus.irq), 0);

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
